id_token_monitor: RTL and testbench
===================================

Name: id_token_monitor

Overview:
- Downstream consumer of the identifier-recognizer FSM. It watches the same 8-bit character stream, one char per clk, together with that FSM's registered match output.
- Delimits complete identifier tokens: a letter, then any letters/digits, ending in a digit, terminated by a non-alphanumeric char.
- Reports each token's length, a running token count and the longest token.
- Cross-checks the recognizer's match output against its own shadow state machine and raises a sticky error on disagreement.

Parameters:
- LEN_W, 8, width of token-length fields; lengths saturate at 2^LEN_W-1.
- CNT_W, 16, width of the token counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- char  input  8  ASCII char, same value and cycle as presented to the recognizer.
- match  input  1  recognizer output; reflects the char presented on the previous cycle.
- id_done  output  1  one-cycle pulse: an identifier token just terminated.
- id_len  output  LEN_W  length of the last completed token, in chars, delimiter excluded.
- id_count  output  CNT_W  number of completed tokens since reset.
- max_len  output  LEN_W  longest completed token since reset.
- err  output  1  sticky: match disagreed with the shadow FSM while in sync.

Behaviour:
- Reset (async, active-high): all outputs 0; shadow state IDLE; char_d=0; run_len=0; synced=0; primed=0.
- Alignment: register char into char_d each cycle. The aligned pair (char_d, match) describes the same char.
- primed goes 1 one cycle after reset deasserts. No pair is processed while primed=0.
- Classes: L = 'a'..'z' or 'A'..'Z'; D = '0'..'9'; O = everything else.
- Shadow FSM, applied to char_d when primed=1:
  - IDLE: L -> ALPHA, run_len=1. D or O -> IDLE, run_len=0. A leading digit never starts a run.
  - ALPHA: L -> ALPHA. D -> DIGIT. O -> IDLE. run_len increments on L/D.
  - DIGIT: L -> ALPHA. D -> DIGIT. run_len increments on L/D.
  - DIGIT on O -> IDLE, token end:
    - id_done=1 next cycle; id_len=run_len.
    - id_count+1.
    - max_len = max(max_len, run_len).
    - run_len cleared.
- Exp = 1 when the next shadow state is DIGIT.
- Sync check, evaluated in the same cycle as the aligned pair:
  - If synced=1 and match != Exp, err <= 1. err stays 1 until reset.
  - synced is set on the first processed O char, where both FSMs are known to be in state 0, and stays set.
  - Rationale: the recognizer has no reset, so a mid-operation reset of this block must not cause false errors.
- run_len saturates at 2^LEN_W-1 and does not wrap. id_len and max_len therefore saturate too.
- id_count wraps to 0 after 2^CNT_W-1.
- Token end while max_len equals run_len: max_len is unchanged.
- id_done is registered: high exactly one cycle, in the cycle after the delimiter appears on char_d. id_len, id_count and max_len update on that same edge.
- Reset asserted mid-token: the token is discarded, nothing is counted, and synced clears.
- Tokens not followed by a delimiter are never reported. This covers a stream ending after a digit, or after a trailing letter such as "a1b ".

Decomposition:
- Shared package id_pkg holds:
  - char-class constants: CH_A_LO, CH_Z_LO, CH_A_UP, CH_Z_UP, CH_0, CH_9;
  - the state encoding ST_IDLE=0, ST_ALPHA=1, ST_DIGIT=2, matching the recognizer's integer states;
  - the class function is_letter / is_digit.
- One natural sub-module, id_char_class: combinational 8-bit char to {L,D,O}. It is shared with the recognizer in future refactors.

Test Plan:
- Reset, then feed "ab12 " with match from a live recognizer -> one id_done pulse two cycles after ' ' is applied; id_len=4, id_count=1, max_len=4, err=0.
- Feed "9x7;a1;" -> two tokens: "x7" then "a1". id_len=2 each, id_count=2, max_len=2; the leading '9' is not counted.
- Feed "abc ab1c " -> no id_done, because neither run ends in a digit; id_count=0.
- Force match=1 for one cycle during a ' ' after sync -> err=1 the next cycle and stays 1 through further valid traffic until reset.
- Assert reset mid "abc1" with the recognizer not reset, then continue "23 x9 " -> no err before the first delimiter. "x9" is counted with id_len=2 and id_count=1; err=0.
- LEN_W=4: feed 'a' plus 20 digits plus ' ' -> id_len=15 (saturated), max_len=15. With CNT_W=2, five tokens -> id_count=1.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the identifier recognizer and its token monitor.
//   - Char-class bounds (ASCII) and the helper class functions.
//   - State encoding shared with the recognizer's integer states.
package id_pkg;

    localparam logic [7:0] CH_A_LO = 8'h61;  // 'a'
    localparam logic [7:0] CH_Z_LO = 8'h7A;  // 'z'
    localparam logic [7:0] CH_A_UP = 8'h41;  // 'A'
    localparam logic [7:0] CH_Z_UP = 8'h5A;  // 'Z'
    localparam logic [7:0] CH_0    = 8'h30;  // '0'
    localparam logic [7:0] CH_9    = 8'h39;  // '9'

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALPHA = 2'd1,
        ST_DIGIT = 2'd2
    } id_state_t;

    typedef enum logic [1:0] {
        CL_O = 2'd0,
        CL_L = 2'd1,
        CL_D = 2'd2
    } char_class_t;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= CH_A_LO) && (c <= CH_Z_LO)) || ((c >= CH_A_UP) && (c <= CH_Z_UP));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational character classifier: letter / digit / other.
// Ports:
//   char  in  8  ASCII character
//   cls   out    class of char (CL_L, CL_D or CL_O)
module id_char_class
    import id_pkg::*;
(
    input  logic [7:0]  char,
    output char_class_t cls
);

    always_comb begin
        cls = CL_O;
        if (is_letter(char))
            cls = CL_L;
        else if (is_digit(char))
            cls = CL_D;
    end

endmodule

// File: rtl/id_token_monitor.sv
// Identifier token monitor. Runs a shadow copy of the identifier recognizer
// on the delayed char stream, reports completed tokens (letter first, ending
// in a digit, closed by a non-alphanumeric char) and flags any disagreement
// with the recognizer's registered match output.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset
//   char      in   8      char stream, same cycle as fed to the recognizer
//   match     in   1      recognizer output for the previous cycle's char
//   id_done   out  1      one-cycle pulse per completed token
//   id_len    out  LEN_W  length of last token (saturating)
//   id_count  out  CNT_W  completed tokens since reset (wrapping)
//   max_len   out  LEN_W  longest token since reset
//   err       out  1      sticky recognizer/shadow disagreement
module id_token_monitor
    import id_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             match,
    output logic             id_done,
    output logic [LEN_W-1:0] id_len,
    output logic [CNT_W-1:0] id_count,
    output logic [LEN_W-1:0] max_len,
    output logic             err
);

    logic [7:0]       char_d;    // aligns char with the recognizer's registered match
    logic             primed;    // first cycle after reset carries no valid pair
    logic             synced;    // both FSMs known to agree on state
    id_state_t        state, state_nx;
    logic [LEN_W-1:0] run_len, run_nx, run_inc;
    logic             tok_end;
    logic             exp_match;
    char_class_t      cls;

    id_char_class u_class (
        .char (char_d),
        .cls  (cls)
    );

    assign run_inc = (&run_len) ? run_len : run_len + LEN_W'(1);

    always_comb begin
        state_nx = state;
        run_nx   = run_len;
        tok_end  = 1'b0;
        unique case (cls)
            CL_L: begin
                state_nx = ST_ALPHA;
                run_nx   = (state == ST_IDLE) ? LEN_W'(1) : run_inc;
            end
            CL_D: begin
                // A digit outside a run never starts one.
                if (state == ST_IDLE) begin
                    state_nx = ST_IDLE;
                    run_nx   = '0;
                end else begin
                    state_nx = ST_DIGIT;
                    run_nx   = run_inc;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                run_nx   = '0;
                tok_end  = (state == ST_DIGIT);
            end
        endcase
    end

    assign exp_match = (state_nx == ST_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_d   <= '0;
            primed   <= 1'b0;
            synced   <= 1'b0;
            state    <= ST_IDLE;
            run_len  <= '0;
            id_done  <= 1'b0;
            id_len   <= '0;
            id_count <= '0;
            max_len  <= '0;
            err      <= 1'b0;
        end else begin
            char_d  <= char;
            primed  <= 1'b1;
            id_done <= 1'b0;
            if (primed) begin
                state   <= state_nx;
                run_len <= run_nx;
                if (synced && (match != exp_match))
                    err <= 1'b1;
                // The recognizer has no reset; only after a delimiter are both
                // machines guaranteed to be idle together.
                if (cls == CL_O)
                    synced <= 1'b1;
                if (tok_end) begin
                    id_done  <= 1'b1;
                    id_len   <= run_len;
                    id_count <= id_count + CNT_W'(1);
                    if (run_len > max_len)
                        max_len <= run_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_token_monitor.sv
module tb_id_token_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ch  = 8'h00;
    logic       mt  = 1'b0;

    logic        d0_done, d0_err, d1_done, d1_err;
    logic [7:0]  d0_len, d0_max;
    logic [15:0] d0_cnt;
    logic [3:0]  d1_len, d1_max;
    logic [1:0]  d1_cnt;

    always #5 clk = ~clk;

    id_token_monitor dut0 (
        .clk(clk), .reset(rst), .char(ch), .match(mt),
        .id_done(d0_done), .id_len(d0_len), .id_count(d0_cnt),
        .max_len(d0_max), .err(d0_err)
    );

    id_token_monitor #(.LEN_W(4), .CNT_W(2)) dut1 (
        .clk(clk), .reset(rst), .char(ch), .match(mt),
        .id_done(d1_done), .id_len(d1_len), .id_count(d1_cnt),
        .max_len(d1_max), .err(d1_err)
    );

    int nchk = 0;
    int nerr = 0;
    bit cmp_on = 1'b1;

    // Recognizer stand-in (never reset): run = chars since the first letter
    // of the current alphanumeric group; match = digit inside such a run.
    int   r_run = 0;
    logic r_m   = 1'b0;

    // Reference model of the monitor.
    int   m_run = 0, m_len = 0, m_cnt = 0, m_max = 0;
    bit   m_prev_exp = 0, m_sync = 0, m_err = 0, m_done = 0;
    logic [7:0] prev_c = 8'h00;
    bit   prev_ok = 0;

    function automatic bit is_l(logic [7:0] c);
        return (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction
    function automatic bit is_d(logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction
    function automatic int clamp(int v, int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic chk(string n, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_len = 0; m_cnt = 0; m_max = 0;
        m_prev_exp = 0; m_sync = 0; m_err = 0; m_done = 0;
    endtask

    // Process one aligned (char, match) pair; results show after the next edge.
    task automatic model_step(logic [7:0] c, bit m);
        bit tok = 0;
        bit expm;
        if (is_l(c))
            m_run++;
        else if (is_d(c)) begin
            if (m_run > 0) m_run++;
        end else begin
            tok = m_prev_exp;
            if (tok) begin
                m_len = m_run;
                m_cnt++;
                if (m_run > m_max) m_max = m_run;
            end
            m_run = 0;
        end
        expm = is_d(c) && (m_run > 0);
        if (m_sync && (m != expm)) m_err = 1;
        if (!is_l(c) && !is_d(c)) m_sync = 1;
        m_prev_exp = expm;
        m_done = tok;
    endtask

    // Drive one char at the falling edge; match carries the recognizer's
    // answer for the previous char (fm forces it high to inject a fault).
    task automatic send(logic [7:0] c, bit r = 0, bit fm = 0);
        bit m;
        @(negedge clk);
        m   = r_m | fm;
        rst = r;
        ch  = c;
        mt  = m;
        if (r) model_clear();
        else if (prev_ok) model_step(prev_c, m);
        else m_done = 0;
        if (is_l(c)) r_run++;
        else if (is_d(c)) begin if (r_run > 0) r_run++; end
        else r_run = 0;
        r_m = is_d(c) && (r_run > 0);
        prev_c  = c;
        prev_ok = !r;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        send(" ", 1);
        send(" ", 1);
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("done0", d0_done, m_done);
            chk("len0",  d0_len,  clamp(m_len, 8));
            chk("cnt0",  d0_cnt,  m_cnt % 65536);
            chk("max0",  d0_max,  clamp(m_max, 8));
            chk("err0",  d0_err,  m_err);
            chk("done1", d1_done, m_done);
            chk("len1",  d1_len,  clamp(m_len, 4));
            chk("cnt1",  d1_cnt,  m_cnt % 4);
            chk("max1",  d1_max,  clamp(m_max, 4));
            chk("err1",  d1_err,  m_err);
        end
    end

    initial begin
        send(8'h00, 1);
        send(8'h00, 1);
        @(posedge clk); #1;
        chk("lit_reset_cnt", d0_cnt, 0);
        chk("lit_reset_err", d0_err, 0);

        // Basic token: id_done two edges after the delimiter is applied.
        send_str("ab12 ");
        send(" ");
        @(posedge clk); #1;
        chk("lit_t1_done", d0_done, 1);
        chk("lit_t1_len",  d0_len, 4);
        chk("lit_t1_cnt",  d0_cnt, 1);
        chk("lit_t1_max",  d0_max, 4);
        chk("lit_t1_err",  d0_err, 0);

        // Leading digit skipped; two tokens.
        do_reset();
        send_str("9x7;a1;  ");
        chk("lit_t2_len", d0_len, 2);
        chk("lit_t2_cnt", d0_cnt, 2);
        chk("lit_t2_max", d0_max, 2);

        // Runs not ending in a digit are not tokens.
        do_reset();
        send_str("abc ab1c   ");
        chk("lit_t3_cnt", d0_cnt, 0);

        // Injected disagreement on a delimiter after sync: sticky err.
        send(" ");
        send("x", 0, 1);
        send_str("9 a1 b2   ");
        chk("lit_t4_err", d0_err, 1);
        chk("lit_t4_err_s", d1_err, 1);
        do_reset();
        send(" ");
        chk("lit_t4_clr", d0_err, 0);

        // Reset mid-token while the recognizer keeps running.
        send_str("ab");
        send("c", 1);
        send("1", 1);
        send_str("23 x9   ");
        chk("lit_t5_err", d0_err, 0);
        chk("lit_t5_cnt", d0_cnt, 1);
        chk("lit_t5_len", d0_len, 2);

        // Length saturation on the narrow instance, count wrap.
        do_reset();
        send("a");
        for (int i = 0; i < 20; i++) send(8'("0" + (i % 10)));
        send(" ");
        send(" ");
        @(posedge clk); #1;
        chk("lit_t6_len_s", d1_len, 15);
        chk("lit_t6_max_s", d1_max, 15);
        chk("lit_t6_len",   d0_len, 21);
        for (int i = 0; i < 4; i++) send_str("x9 ");
        send_str("  ");
        chk("lit_t6_cnt_s", d1_cnt, 1);
        chk("lit_t6_cnt",   d0_cnt, 5);
        chk("lit_t6_maxf",  d0_max, 21);
        send_str("a1");

        @(negedge clk);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
